io_board_bridge: RTL and testbench

- Board-side end of the single-cycle computer's memory-mapped I/O ports. The CPU drives out_port0..2 and samples in_port0..2; this block sits on the far side of those ports.
- Input direction: switches and keys are synchronised, debounced and registered, then presented as in_port0..2.
- Output direction: out_port0..2 are converted to decimal by a sequential double-dabble FSM. The results are driven onto six active-low seven-segment displays, two digits per port.

---
 rtl/io_board_pkg.sv | 35 +++
 rtl/io_debounce.sv | 58 +++++
 rtl/io_board_bridge.sv | 170 +++++++++++++++++
 tb/tb_io_board_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_board_pkg.sv
// Shared constants for the board-side I/O bridge: seven-segment glyphs,
// double-dabble FSM states and port-index width.
package io_board_pkg;

    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_STORE
    } dd_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry 0 is the rightmost element: SEG_DIGIT[d] is the glyph for d.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_glyph(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[d];
    endfunction

    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Per-bit two-flop synchroniser followed by a counting debouncer;
// the stable value flips only after DEBOUNCE_CYCLES consecutive mismatches.
module io_debounce #(
    parameter int               WIDTH           = 1,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/io_board_bridge.sv
// Board side of the CPU I/O ports: debounced switches/keys in, and a
// round-robin double-dabble converter driving six seven-segment displays.
module io_board_bridge
    import io_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int NUM_SW          = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw,
    input  logic [3:1]        key,
    input  logic [31:0]       out_port0,
    input  logic [31:0]       out_port1,
    input  logic [31:0]       out_port2,
    output logic [31:0]       in_port0,
    output logic [31:0]       in_port1,
    output logic [31:0]       in_port2,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
);

    logic [NUM_SW-1:0] sw_stable;
    logic [2:0]        key_stable;

    io_debounce #(
        .WIDTH          (NUM_SW),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      ({NUM_SW{1'b0}})
    ) u_sw_db (
        .clock(clock),
        .reset(reset),
        .din  (sw),
        .dout (sw_stable)
    );

    io_debounce #(
        .WIDTH          (3),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (3'b111)
    ) u_key_db (
        .clock(clock),
        .reset(reset),
        .din  (key),
        .dout (key_stable)
    );

    // Stable registers feed the ports directly; keys report 1 = pressed.
    assign in_port0 = {27'b0, sw_stable[4:0]};
    assign in_port1 = {27'b0, sw_stable[9:5]};
    assign in_port2 = {29'b0, ~key_stable};

    dd_state_e state_q, state_d;
    port_idx_t idx_q, idx_d;
    logic [6:0] val_q, val_d;
    logic       ovf_q, ovf_d;
    logic [7:0] bcd_q, bcd_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] hex_q [6];
    logic [6:0] hex_d [6];

    logic [31:0] port_word;
    logic [6:0]  tens_seg;
    logic [6:0]  units_seg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            val_q   <= '0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    always_comb begin
        port_word = out_port0;
        unique case (idx_q)
            2'd1:    port_word = out_port1;
            2'd2:    port_word = out_port2;
            default: port_word = out_port0;
        endcase
    end

    always_comb begin
        tens_seg  = seg_glyph(bcd_q[7:4]);
        units_seg = seg_glyph(bcd_q[3:0]);
        if (ovf_q) begin
            tens_seg  = SEG_DASH;
            units_seg = SEG_DASH;
        end else if (bcd_q[7:4] == 4'd0) begin
            tens_seg = SEG_BLANK;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 6; i++) begin
            hex_d[i] = hex_q[i];
        end
        unique case (state_q)
            ST_LOAD: begin
                val_d   = port_word[6:0];
                ovf_d   = port_word > 32'd99;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                {bcd_d, val_d} = {dd_adjust(bcd_q[7:4]),
                                  dd_adjust(bcd_q[3:0]),
                                  val_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                unique case (idx_q)
                    2'd1: begin
                        hex_d[2] = units_seg;
                        hex_d[3] = tens_seg;
                    end
                    2'd2: begin
                        hex_d[4] = units_seg;
                        hex_d[5] = tens_seg;
                    end
                    default: begin
                        hex_d[0] = units_seg;
                        hex_d[1] = tens_seg;
                    end
                endcase
                idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_io_board_bridge.sv
// Bench for io_board_bridge: behavioural display/debounce model checked
// every cycle, plus directed literal expectations and random stimulus.
module tb_io_board_bridge;

    localparam int DC = 4;
    localparam logic [12:0] RAW_RST = {3'b111, 10'b0};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  sw;
    logic [3:1]  key;
    logic [31:0] op0, op1, op2;
    logic [31:0] in_port0, in_port1, in_port2;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    always #5 clock = ~clock;

    io_board_bridge #(
        .DEBOUNCE_CYCLES(DC),
        .NUM_SW         (10)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sw       (sw),
        .key      (key),
        .out_port0(op0),
        .out_port1(op1),
        .out_port2(op2),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .in_port2 (in_port2),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Model state
    logic [6:0]  m_hex [6];
    logic [12:0] m_stab;
    logic [12:0] hist [DC+2];
    logic [31:0] pend;
    logic [31:0] mv;
    int          n;
    int          mp;
    bit          flip;

    // Displays: port p is sampled on cycle 27k+9p+1 and shown on 27k+9p+9.
    // Inputs: a bit flips once its last DC synchronised samples all differ.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            n = 0;
            m_stab = RAW_RST;
            for (int k = 0; k < DC + 2; k++) hist[k] = RAW_RST;
            for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
        end else begin
            n++;
            for (int k = DC + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {key, sw};
            for (int b = 0; b < 13; b++) begin
                flip = 1'b1;
                for (int k = 2; k < DC + 2; k++)
                    if (hist[k][b] == m_stab[b]) flip = 1'b0;
                if (flip) m_stab[b] = ~m_stab[b];
            end
            if ((n - 1) % 9 == 0) begin
                mp = ((n - 1) / 9) % 3;
                pend = (mp == 0) ? op0 : (mp == 1) ? op1 : op2;
            end
            if (n % 9 == 0) begin
                mp = (n / 9 - 1) % 3;
                mv = pend;
                if (mv > 99) begin
                    m_hex[2*mp]   = 7'h3F;
                    m_hex[2*mp+1] = 7'h3F;
                end else begin
                    m_hex[2*mp]   = glyph(int'(mv % 10));
                    m_hex[2*mp+1] = (mv / 10 == 0) ? 7'h7F
                                                   : glyph(int'(mv / 10));
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("hex0", {25'b0, hex0}, {25'b0, m_hex[0]});
            chk("hex1", {25'b0, hex1}, {25'b0, m_hex[1]});
            chk("hex2", {25'b0, hex2}, {25'b0, m_hex[2]});
            chk("hex3", {25'b0, hex3}, {25'b0, m_hex[3]});
            chk("hex4", {25'b0, hex4}, {25'b0, m_hex[4]});
            chk("hex5", {25'b0, hex5}, {25'b0, m_hex[5]});
            chk("in_port0", in_port0, {27'b0, m_stab[4:0]});
            chk("in_port1", in_port1, {27'b0, m_stab[9:5]});
            chk("in_port2", in_port2, {29'b0, ~m_stab[12:10]});
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clock);
    endtask

    logic [31:0] rv;

    initial begin
        sw  = '0;
        key = 3'b111;
        op0 = '0;
        op1 = '0;
        op2 = '0;
        #1 reset = 1'b1;
        cyc(2);
        cmp_en = 1'b1;
        chk("rst_hex0", {25'b0, hex0}, 32'h7F);
        chk("rst_in2", in_port2, 32'h0);

        op0 = 32'd42;
        op1 = 32'd7;
        op2 = 32'd99;
        reset = 1'b0;
        cyc(8);
        chk("hex0_before_store", {25'b0, hex0}, 32'h7F);
        cyc(1);
        chk("hex0_first_store", {25'b0, hex0}, 32'h24);
        chk("hex1_42", {25'b0, hex1}, 32'h19);
        cyc(27);
        chk("hex3_7", {25'b0, hex3}, 32'h7F);
        chk("hex2_7", {25'b0, hex2}, 32'h78);
        chk("hex5_99", {25'b0, hex5}, 32'h10);
        chk("hex4_99", {25'b0, hex4}, 32'h10);

        op1 = 32'd100;
        op2 = 32'h8000_0005;
        op0 = 32'd0;
        cyc(36);
        chk("hex3_ovf", {25'b0, hex3}, 32'h3F);
        chk("hex2_ovf", {25'b0, hex2}, 32'h3F);
        chk("hex5_ovf", {25'b0, hex5}, 32'h3F);
        chk("hex4_ovf", {25'b0, hex4}, 32'h3F);
        chk("hex1_zero", {25'b0, hex1}, 32'h7F);
        chk("hex0_zero", {25'b0, hex0}, 32'h40);

        sw = 10'b10101_00011;
        cyc(5);
        chk("sw_lat5_in0", in_port0, 32'd0);
        cyc(1);
        chk("sw_lat6_in0", in_port0, 32'd3);
        chk("sw_lat6_in1", in_port1, 32'd21);

        sw = 10'b10101_00010;
        cyc(3);
        sw = 10'b10101_00011;
        cyc(8);
        chk("glitch_in0", in_port0, 32'd3);

        key = 3'b101;
        cyc(5);
        chk("key_lat5", in_port2, 32'd0);
        cyc(1);
        chk("key_press", in_port2, 32'd2);
        cyc(4);
        key = 3'b111;
        cyc(5);
        chk("key_rel5", in_port2, 32'd2);
        cyc(1);
        chk("key_release", in_port2, 32'd0);

        for (int i = 0; i < 20 && (n % 9) != 3; i++) cyc(1);
        chk("align_shift", n % 9, 32'd3);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_hex0", {25'b0, hex0}, 32'h7F);
        chk("arst_hex2", {25'b0, hex2}, 32'h7F);
        chk("arst_hex5", {25'b0, hex5}, 32'h7F);
        chk("arst_in0", in_port0, 32'd0);
        chk("arst_in1", in_port1, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        cyc(9);
        chk("restart_hex0", {25'b0, hex0}, 32'h40);
        chk("restart_hex1", {25'b0, hex1}, 32'h7F);
        chk("restart_in1", in_port1, 32'd21);

        for (int i = 0; i < 900; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0: rv = $urandom_range(0, 99);
                    1: rv = $urandom_range(99, 100);
                    2: rv = $urandom_range(0, 9);
                    default: rv = $urandom;
                endcase
                case ($urandom_range(0, 2))
                    0: op0 = rv;
                    1: op1 = rv;
                    default: op2 = rv;
                endcase
            end
            if ($urandom_range(0, 5) == 0)
                sw[$urandom_range(0, 9)] = ~sw[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0)
                key = 3'($urandom_range(0, 7));
        end
        cyc(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
